// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache miss port, the D-cache miss port and the shared memory
// port of the arbiter. The arbiter takes the master view; the environment
// (caches and memory) takes the slave view.
interface mem_arbiter_if #(
    parameter int BLOCK_W = 128,
    parameter int ADDR_W  = 6
);
    // I-cache side
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_busywait;

    // D-cache side
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_busywait;

    // memory side
    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    modport master (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_writedata,
        input  mem_readdata, mem_busywait,
        output i_readdata, i_busywait,
        output d_readdata, d_busywait,
        output mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        output i_read, i_address,
        output d_read, d_write, d_address, d_writedata,
        output mem_readdata, mem_busywait,
        input  i_readdata, i_busywait,
        input  d_readdata, d_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between the I-cache (read only)
// and the D-cache (read and write-back). One transaction is in flight at a time.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no strobes; on any request pick a grant and launch the access
//  ISSUE | strobes up, memory busy ignored while memory reacts to strobe
//  WAIT  | strobes held; on memory not busy capture read data, drop strobes
//  DONE  | granted busywait released for this one cycle; remember grant
module mem_arbiter #(
    parameter int BLOCK_W = 128,
    parameter int ADDR_W  = 6
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state,       state_nxt;
    logic               grant_d,     grant_d_nxt;   // 1: D-cache owns the transaction
    logic               last_d,      last_d_nxt;    // 1: D-cache was granted last
    logic               mem_read_q,  mem_read_nxt;
    logic               mem_write_q, mem_write_nxt;
    logic [ADDR_W-1:0]  addr_q,      addr_nxt;
    logic [BLOCK_W-1:0] wdata_q,     wdata_nxt;
    logic [BLOCK_W-1:0] i_rdata_q,   i_rdata_nxt;
    logic [BLOCK_W-1:0] d_rdata_q,   d_rdata_nxt;

    logic               i_req;
    logic               d_req;
    logic               pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // On a tie the requester that was not served last wins.
    assign pick_d = d_req & (~i_req | ~last_d);

    // State and registered outputs; reset clears last-grant to I so D wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_d     <= 1'b0;
            last_d      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nxt;
            grant_d     <= grant_d_nxt;
            last_d      <= last_d_nxt;
            mem_read_q  <= mem_read_nxt;
            mem_write_q <= mem_write_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            i_rdata_q   <= i_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    // Next-state and next-output decode for the transaction sequencer.
    always_comb begin
        state_nxt     = state;
        grant_d_nxt   = grant_d;
        last_d_nxt    = last_d;
        mem_read_nxt  = mem_read_q;
        mem_write_nxt = mem_write_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        i_rdata_nxt   = i_rdata_q;
        d_rdata_nxt   = d_rdata_q;

        case (state)
            IDLE: begin
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                if (i_req | d_req) begin
                    grant_d_nxt = pick_d;
                    state_nxt   = ISSUE;
                    if (pick_d) begin
                        // write wins when both D strobes are (illegally) high
                        addr_nxt      = bus.d_address;
                        mem_write_nxt = bus.d_write;
                        mem_read_nxt  = ~bus.d_write;
                        if (bus.d_write) begin
                            wdata_nxt = bus.d_writedata;
                        end
                    end else begin
                        addr_nxt     = bus.i_address;
                        mem_read_nxt = 1'b1;
                    end
                end
            end

            ISSUE: begin
                state_nxt = WAIT;
            end

            WAIT: begin
                if (!bus.mem_busywait) begin
                    // a requester that let go mid-flight gets nothing back
                    if (mem_read_q) begin
                        if (grant_d && bus.d_read) begin
                            d_rdata_nxt = bus.mem_readdata;
                        end else if (!grant_d && bus.i_read) begin
                            i_rdata_nxt = bus.mem_readdata;
                        end
                    end
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    state_nxt     = DONE;
                end
            end

            DONE: begin
                last_d_nxt = grant_d;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt     = IDLE;
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
            end
        endcase
    end

    // Stall is combinational so it tracks the request even while reset is held.
    assign bus.i_busywait = i_req & ~((state == DONE) & ~grant_d);
    assign bus.d_busywait = d_req & ~((state == DONE) &  grant_d);

    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = addr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.i_readdata    = i_rdata_q;
    assign bus.d_readdata    = d_rdata_q;

endmodule
